// File: rtl/keypad_loader_if.sv
// Keypad loader bus: raw key lines and inhibit in, BCD digit and load strobe out.
// The master side drives the keypad and inhibit; the slave side is the loader itself.
interface keypad_loader_if;
  logic [9:0] keypad;
  logic       inhibit;
  logic [3:0] data;
  logic       loadn;
  logic       key_held;

  modport master (output keypad, inhibit, input data, loadn, key_held);
  modport slave  (input keypad, inhibit, output data, loadn, key_held);
endinterface

// File: rtl/keypad_loader.sv
// Keypad loader: synchronizes and debounces a 10-key decimal keypad and turns each
// accepted press into one active-low load strobe carrying the BCD digit for MS_Timer.
// A key must be seen alone for DEBOUNCE_CYCLES samples to load, and all keys must be
// released for DEBOUNCE_CYCLES samples before another press is considered.
module keypad_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input logic            clock,
  input logic            clrn,
  keypad_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    LOAD,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [9:0]       sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       data_q, data_d;
  logic             loadn_q, loadn_d;
  logic             held_q, held_d;

  logic [3:0]       ksOnes;
  logic [3:0]       ksIdx;
  logic             ksNone, ksSingle;

  // Two-flop synchronizer for the asynchronous key lines
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.keypad;
      sync2_q <= sync1_q;
    end
  end

  // Classify the synchronized keys as none, exactly one (with its index), or several
  always_comb begin
    ksOnes = '0;
    ksIdx  = '0;
    for (int i = 0; i < 10; i++) begin
      ksOnes = ksOnes + {3'b000, sync2_q[i]};
      if (sync2_q[i]) ksIdx = 4'(i);
    end
    ksNone   = (ksOnes == 4'd0);
    ksSingle = (ksOnes == 4'd1);
  end

  // Press/release debounce sequencing; the strobe is only low for the cycle spent in LOAD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    data_d  = data_q;
    loadn_d = 1'b1;
    held_d  = held_q;
    case (state_q)
      IDLE: begin
        if (ksSingle && !bus.inhibit) begin
          state_d = DEBOUNCE;
          cnt_d   = CNT_ONE;
          cand_d  = ksIdx;
        end
      end
      DEBOUNCE: begin
        if (!ksSingle || (ksIdx != cand_q) || bus.inhibit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOAD;
          data_d  = cand_q;
          loadn_d = 1'b0;
          held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOAD: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        if (ksNone) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            held_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any press in progress
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      data_q  <= '0;
      loadn_q <= 1'b1;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      data_q  <= data_d;
      loadn_q <= loadn_d;
      held_q  <= held_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.loadn    = loadn_q;
  assign bus.key_held = held_q;

endmodule
